// File: rtl/sample_framer_pkg.sv
// Shared types and defaults for the per-antenna sample framer.
package pr3_pkg;

    localparam int DATA_WIDTH_DEF = 14;
    localparam int LOG2_N_DEF     = 11;

    typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    typedef enum logic {
        WR_WRITE = 1'b0,
        WR_DROP  = 1'b1
    } wr_mode_t;

endpackage

// File: rtl/sample_framer_ram.sv
// Ping-pong frame storage: simple dual-port RAM, one write port and a
// registered, read-enabled read port (block-RAM style).
module frame_bank_ram #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value while re_i is low; this is the output
    // register the framer stalls on.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_framer.sv
// ADC capture stage: converts samples to two's complement, buffers 2^LOG2_N
// sample frames in a ping-pong RAM and streams whole frames out.
import pr3_pkg::*;

module sample_framer #(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int LOG2_N        = LOG2_N_DEF,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sink,
    input  logic                  sink_en,
    output logic [DATA_WIDTH-1:0] source_data,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic                  overflow,
    output logic [15:0]           dropped_frames
);

    localparam int                AW        = LOG2_N + 1;
    localparam logic [LOG2_N-1:0] LAST_ADDR = '1;

    logic [DATA_WIDTH-1:0] conv;

    logic [LOG2_N-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;
    wr_mode_t          wr_mode_q, wr_mode_d, cur_mode;
    logic [1:0]        full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       dropped_q, dropped_d;
    logic              ram_we, set_full, clr_full;

    rd_state_t         rd_state_q, rd_state_d;
    logic [LOG2_N-1:0] rd_addr_q, rd_addr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              ram_re;
    logic [LOG2_N-1:0] ram_raddr_lo;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        conv = sink;
        if (OFFSET_BINARY != 0) begin
            conv[DATA_WIDTH-1] = ~sink[DATA_WIDTH-1];
        end
    end

    // The mode is latched on a frame's first sample from the registered full
    // flag, so a bank released in that same cycle still yields a DROP frame.
    always_comb begin
        cur_mode = wr_mode_q;
        if (wr_addr_q == '0) begin
            cur_mode = full_q[wr_bank_q] ? WR_DROP : WR_WRITE;
        end
        wr_addr_d  = wr_addr_q;
        wr_bank_d  = wr_bank_q;
        wr_mode_d  = wr_mode_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        ram_we     = 1'b0;
        set_full   = 1'b0;
        if (sink_en) begin
            wr_mode_d = cur_mode;
            wr_addr_d = wr_addr_q + LOG2_N'(1);
            if (cur_mode == WR_WRITE) begin
                ram_we = 1'b1;
                if (wr_addr_q == LAST_ADDR) begin
                    set_full  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                end
            end else if (wr_addr_q == '0) begin
                overflow_d = 1'b1;
                if (dropped_q != '1) begin
                    dropped_d = dropped_q + 16'd1;
                end
            end
        end
    end

    // The RAM read register doubles as the output data register; a read is
    // only issued when the current beat is consumed, so data holds on stall.
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_addr_d    = rd_addr_q;
        rd_bank_d    = rd_bank_q;
        valid_d      = valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        ram_re       = 1'b0;
        ram_raddr_lo = rd_addr_q;
        clr_full     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    ram_re       = 1'b1;
                    ram_raddr_lo = '0;
                    rd_addr_d    = LOG2_N'(1);
                    valid_d      = 1'b1;
                    sop_d        = 1'b1;
                    eop_d        = 1'b0;
                    rd_state_d   = RD_STREAM;
                end
            end
            default: begin
                if (source_ready) begin
                    if (eop_q) begin
                        clr_full   = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        rd_addr_d  = '0;
                        valid_d    = 1'b0;
                        sop_d      = 1'b0;
                        eop_d      = 1'b0;
                        rd_state_d = RD_IDLE;
                    end else begin
                        ram_re    = 1'b1;
                        rd_addr_d = rd_addr_q + LOG2_N'(1);
                        sop_d     = 1'b0;
                        eop_d     = (rd_addr_q == LAST_ADDR);
                    end
                end
            end
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q  <= '0;
            wr_bank_q  <= 1'b0;
            wr_mode_q  <= WR_WRITE;
            full_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_bank_q  <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            wr_bank_q  <= wr_bank_d;
            wr_mode_q  <= wr_mode_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_bank_q  <= rd_bank_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
        end
    end

    frame_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clk),
        .rst_i   (reset),
        .we_i    (ram_we),
        .waddr_i ({wr_bank_q, wr_addr_q}),
        .wdata_i (conv),
        .re_i    (ram_re),
        .raddr_i ({rd_bank_q, ram_raddr_lo}),
        .rdata_o (ram_rdata)
    );

    assign source_data    = ram_rdata;
    assign source_valid   = valid_q;
    assign source_sop     = sop_q;
    assign source_eop     = eop_q;
    assign overflow       = overflow_q;
    assign dropped_frames = dropped_q;

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: stimulus pushes expected beats, monitors
// pop and compare on every output handshake.
module tb_sample_framer;

    localparam int DW = 14;
    localparam int LN = 11;
    localparam int N  = 1 << LN;
    localparam int N2 = 4;

    typedef struct {
        int data;
        bit sop;
        bit eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] sink = '0;
    logic          sink_en = 1'b0;
    logic [DW-1:0] source_data;
    logic          source_valid;
    logic          source_ready;
    logic          source_sop;
    logic          source_eop;
    logic          overflow;
    logic [15:0]   dropped_frames;

    logic [DW-1:0] sink2 = '0;
    logic          sink2_en = 1'b0;
    logic [DW-1:0] source2_data;
    logic          source2_valid;
    logic          source2_ready;
    logic          source2_sop;
    logic          source2_eop;
    logic          overflow2;
    logic [15:0]   dropped2;

    beat_t exp_q[$];
    beat_t exp2_q[$];
    int    sop_cyc[$];
    int    eop_cyc[$];
    int    wr_end[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    beats   = 0;
    int    last_wr = 0;
    int    ready_mode = 1;

    sample_framer #(
        .DATA_WIDTH    (DW),
        .LOG2_N        (LN),
        .OFFSET_BINARY (1)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .sink           (sink),
        .sink_en        (sink_en),
        .source_data    (source_data),
        .source_valid   (source_valid),
        .source_ready   (source_ready),
        .source_sop     (source_sop),
        .source_eop     (source_eop),
        .overflow       (overflow),
        .dropped_frames (dropped_frames)
    );

    sample_framer #(
        .DATA_WIDTH    (DW),
        .LOG2_N        (2),
        .OFFSET_BINARY (0)
    ) u_dut2 (
        .clk            (clk),
        .reset          (reset),
        .sink           (sink2),
        .sink_en        (sink2_en),
        .source_data    (source2_data),
        .source_valid   (source2_valid),
        .source_ready   (source2_ready),
        .source_sop     (source2_sop),
        .source_eop     (source2_eop),
        .overflow       (overflow2),
        .dropped_frames (dropped2)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial source2_ready = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offset-binary reading: code minus half scale.
    function automatic int ob_conv(input logic [DW-1:0] r);
        return int'(r) - (1 << (DW - 1));
    endfunction

    function automatic int tc_conv(input logic [DW-1:0] r);
        int v = int'(r);
        if (v >= (1 << (DW - 1))) v = v - (1 << DW);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] raw, input int gap);
        sink    = raw;
        sink_en = 1'b1;
        last_wr = cyc;
        step();
        sink_en = 1'b0;
        repeat (gap) step();
    endtask

    // mode 0: 8192+i, 1: random, 2: tagged by frame, 3: conversion corners then random
    task automatic feed_frame(input int mode, input int tag, input int gap, input bit keep);
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] raw;
            case (mode)
                0:       raw = DW'(8192 + i);
                1:       raw = DW'($urandom);
                2:       raw = DW'(8192 + tag * N + i);
                default: raw = (i == 0) ? DW'(0) : (i == 1) ? DW'(16383) : DW'($urandom);
            endcase
            if (keep) exp_q.push_back('{ob_conv(raw), (i == 0), (i == N - 1)});
            send(raw, gap);
        end
        if (keep) wr_end.push_back(last_wr);
    endtask

    task automatic clear_logs();
        sop_cyc.delete();
        eop_cyc.delete();
        wr_end.delete();
        beats = 0;
    endtask

    task automatic wait_drain(input string name);
        int budget = 20000;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        chk({name, "_drain_left"}, exp_q.size() + exp2_q.size(), 0);
        repeat (8) step();
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_valid"}, source_valid, 0);
        chk({name, "_sop"}, source_sop, 0);
        chk({name, "_eop"}, source_eop, 0);
        chk({name, "_data"}, source_data, 0);
        chk({name, "_overflow"}, overflow, 0);
        chk({name, "_dropped"}, dropped_frames, 0);
    endtask

    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       source_ready = 1'b0;
                1:       source_ready = 1'b1;
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic          pv_stall = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          p_sop = 1'b0;
    logic          p_eop = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            pv_stall <= 1'b0;
        end else begin
            if (pv_stall) begin
                chk("stall_hold", {source_valid, source_data, source_sop, source_eop},
                    {1'b1, p_data, p_sop, p_eop});
            end
            if (source_valid && source_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0d, expected no beat (cycle %0d)",
                             $signed(source_data), cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", int'($signed(source_data)), e.data);
                    chk("beat_sop", source_sop, e.sop);
                    chk("beat_eop", source_eop, e.eop);
                end
                if (source_eop) eop_cyc.push_back(cyc);
            end
            if (source_valid && source_sop && !pv_stall) sop_cyc.push_back(cyc);
            pv_stall <= source_valid && !source_ready;
            p_data   <= source_data;
            p_sop    <= source_sop;
            p_eop    <= source_eop;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!reset && source2_valid && source2_ready) begin
            if (exp2_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat2: got data %0d, expected no beat", $signed(source2_data));
            end else begin
                e = exp2_q.pop_front();
                chk("beat2_data", int'($signed(source2_data)), e.data);
                chk("beat2_sop", source2_sop, e.sop);
                chk("beat2_eop", source2_eop, e.eop);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [DW-1:0] corner [N2];
        step();
        reset = 1'b1;
        repeat (3) step();
        check_zero_outputs("reset");
        reset = 1'b0;

        // single frame, 50% duty, ready high; sop two cycles after last write
        clear_logs();
        feed_frame(0, 0, 1, 1'b1);
        wait_drain("t1");
        chk("t1_beats", beats, N);
        if (sop_cyc.size() == 1 && wr_end.size() == 1)
            chk("t1_sop_latency", sop_cyc[0] - wr_end[0], 2);
        else
            chk("t1_sop_count", sop_cyc.size(), 1);

        // random backpressure
        clear_logs();
        ready_mode = 2;
        feed_frame(0, 0, 1, 1'b1);
        wait_drain("t2");
        ready_mode = 1;
        chk("t2_beats", beats, N);
        chk("t2_overflow", overflow, 0);

        // eight random frames, capture order and per-frame latency
        clear_logs();
        for (int f = 0; f < 8; f++) feed_frame(1, f, 1, 1'b1);
        wait_drain("t4");
        chk("t4_frames", eop_cyc.size(), 8);
        if (sop_cyc.size() == 8 && wr_end.size() == 8) begin
            for (int f = 0; f < 8; f++) chk("t4_sop_latency", sop_cyc[f] - wr_end[f], 2);
        end else begin
            chk("t4_sop_count", sop_cyc.size(), 8);
        end
        chk("t4_overflow", overflow, 0);
        chk("t4_dropped", dropped_frames, 0);

        // stalled output: third frame dropped whole, fourth captured later
        clear_logs();
        ready_mode = 0;
        feed_frame(2, 0, 0, 1'b1);
        feed_frame(2, 1, 0, 1'b1);
        feed_frame(2, 2, 0, 1'b0);
        step();
        chk("t3_overflow", overflow, 1);
        chk("t3_dropped", dropped_frames, 1);
        ready_mode = 1;
        wait_drain("t3a");
        if (eop_cyc.size() >= 1 && sop_cyc.size() >= 2)
            chk("t3_b2b_gap", sop_cyc[1] - eop_cyc[0], 2);
        else
            chk("t3_b2b_sops", sop_cyc.size(), 2);
        feed_frame(2, 3, 0, 1'b1);
        wait_drain("t3b");
        chk("t3_frames", eop_cyc.size(), 3);
        chk("t3_dropped_final", dropped_frames, 1);
        chk("t3_overflow_sticky", overflow, 1);

        // reset mid-frame discards the partial frame
        for (int i = 0; i < 1000; i++) send(DW'($urandom), 0);
        reset = 1'b1;
        step();
        check_zero_outputs("t5_reset");
        clear_logs();
        exp_q.delete();
        reset = 1'b0;
        feed_frame(1, 0, 1, 1'b1);
        wait_drain("t5");
        chk("t5_beats", beats, N);
        chk("t5_frames", eop_cyc.size(), 1);

        // conversion corners on both parameterisations
        clear_logs();
        feed_frame(3, 0, 0, 1'b1);
        corner[0] = DW'(8192);
        corner[1] = DW'(8191);
        corner[2] = DW'(0);
        corner[3] = DW'(16383);
        for (int i = 0; i < N2; i++) begin
            exp2_q.push_back('{tc_conv(corner[i]), (i == 0), (i == N2 - 1)});
            sink2    = corner[i];
            sink2_en = 1'b1;
            step();
        end
        sink2_en = 1'b0;
        wait_drain("t6");
        chk("t6_beats", beats, N);
        chk("t6_overflow2", overflow2, 0);
        chk("t6_dropped2", dropped2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Capture stage directly upstream of the per-antenna phase extraction / FFT stage; one instance per antenna.
- Converts raw ADC words to two's complement.
- Groups samples into frames of 2^LOG2_N using a ping-pong RAM.
- Streams each complete frame out with valid/ready and sop/eop framing. Whole frames are dropped on overflow, so frame alignment is never broken.

Parameters:
DATA_WIDTH, 14, bits per ADC sample
LOG2_N, 11, log2 of frame length (N = 2048 samples)
OFFSET_BINARY, 1, 1: ADC is offset-binary (invert MSB); 0: already two's complement

Ports:
clk  input  1  main clock, 50MHz
reset  input  1  synchronous, active-high reset
sink  input  DATA_WIDTH  raw ADC word
sink_en  input  1  sample strobe; sink is valid when high
source_data  output  DATA_WIDTH  signed sample to FFT stage
source_valid  output  1  beat valid
source_ready  input  1  downstream accepts beat
source_sop  output  1  first beat of frame
source_eop  output  1  last beat of frame
overflow  output  1  sticky; set when any frame dropped
dropped_frames  output  16  count of dropped frames, saturating at 0xFFFF

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset clears:
  - both bank-full flags, wr_addr, wr_bank, rd_addr, rd_bank, write mode (WRITE);
  - read state IDLE, source_valid/sop/eop=0, source_data=0, overflow=0, dropped_frames=0.
  - Partial frames are discarded. sink_en is ignored while reset is high.
- Conversion: OFFSET_BINARY=1 gives out = {~sink[MSB], sink[MSB-1:0]}; otherwise out = sink.
- Write side (on each sink_en):
  - When wr_addr==0, choose mode for the whole frame: WRITE if full[wr_bank]==0 as registered this cycle, else DROP.
  - Release of that bank in the same cycle does NOT count, so the frame is DROP.
  - WRITE: store at {wr_bank, wr_addr}.
  - DROP: discard the sample. On the frame's first sample, set overflow and increment dropped_frames (saturating).
  - wr_addr increments and wraps at N-1.
  - On the N-1 sample in WRITE: set full[wr_bank] at the next edge and toggle wr_bank. DROP frames do not toggle wr_bank.
- Read side, states IDLE/STREAM:
  - IDLE: if full[rd_bank], issue RAM read of address 0 and go to STREAM.
  - RAM has a registered read: data appears 1 cycle after the read is issued.
  - The output register and rd_addr advance only when (!source_valid || source_ready).
  - source_data/sop/eop stay stable while source_valid && !source_ready.
  - Beat k carries the sample at address k. sop is asserted on k=0, eop on k=N-1.
  - On eop handshake in cycle e: at edge e+1, clear full[rd_bank], toggle rd_bank, go to IDLE, drop source_valid.
- Latency:
  - Last write of a frame in cycle t gives the sop beat valid in cycle t+2 (reader idle).
  - Back-to-back frames: next sop valid in cycle e+2 (one idle cycle).
- Throughput: sustained without drops when sink_en duty ≤ N/(N+2) and source_ready is held high.
- Bank ordering: frames are output strictly in capture order.

Decomposition:
- Package pr3_pkg:
  - DATA_WIDTH_DEF=14, LOG2_N_DEF=11;
  - typedef logic signed [DATA_WIDTH-1:0] sample_t;
  - enum rd_state_t {RD_IDLE, RD_STREAM};
  - enum wr_mode_t {WR_WRITE, WR_DROP}.
- Sub-module frame_bank_ram:
  - simple dual-port, 2^(LOG2_N+1) x DATA_WIDTH;
  - one write port; registered read with read-enable; infers block RAM.

Test Plan:
1. Reset; 2048 sink_en pulses every other cycle with sink=8192+i; ready=1.
   -> exactly 2048 beats, values 0..2047; sop on value 0, eop on 2047; sop valid 2 cycles after last write.
2. Same stimulus, source_ready random 50%.
   -> identical beat sequence; data/sop/eop held stable on every stalled cycle; no drops.
3. source_ready=0; feed 3 frames (values tagged by frame), then ready=1.
   -> overflow=1, dropped_frames=1; output is frame0 then frame1; the 4th fed frame is captured and output next.
4. sink_en every other cycle for 8 frames, ready=1.
   -> 8 complete frames in order, overflow=0, one idle cycle between eop and next sop.
5. After 1000 samples, 1-cycle reset, then 2048 samples.
   -> outputs zero during reset; exactly one frame out, starting with the first post-reset sample.
6. OFFSET_BINARY=1: sink=0x0000 -> -8192; sink=0x3FFF -> 8191. OFFSET_BINARY=0: sink=0x2000 -> -8192.
